sprite_walker: RTL and testbench

- Parametrised player/actor sprite engine for the 320x240 game field.
- Takes keyboard movement and a damage pulse, and keeps position, facing direction and walk-animation phase.
- Runs a hit/knockback/blink mode.
- Per pixel, reports sprite ownership and the sprite-sheet ROM address for the colour mapper.
- Sheet layout: 4 directions (0 down, 1 left, 2 up, 3 right) x N_FRAMES frames each; frame 0 is the standing pose.

---
 rtl/sprite_walker.sv | 224 ++++++++++++++++++++++
 tb/tb_sprite_walker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_walker.sv
// Player sprite engine: keyboard walking with clamped movement, walk-cycle phase,
// hit/knockback/blink mode, and per-pixel ownership plus sprite-sheet ROM addressing.
module sprite_walker #(
   parameter int SPR_W     = 40,
   parameter int SPR_H     = 64,
   parameter int N_FRAMES  = 3,
   parameter int DIV       = 4,
   parameter int STEP      = 2,
   parameter int KNOCK     = 8,
   parameter int HIT_TICKS = 16,
   parameter int START_X   = 160,
   parameter int START_Y   = 120,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = 319,
   parameter int Y_MIN     = 0,
   parameter int Y_MAX     = 239,
   parameter int ADDR_W    = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_clk,
   input  logic [7:0]        keycode,
   input  logic              hit,
   input  logic [8:0]        PixelX,
   input  logic [8:0]        PixelY,
   output logic              is_obj,
   output logic [ADDR_W-1:0] obj_address,
   output logic [9:0]        pos_x,
   output logic [9:0]        pos_y,
   output logic [1:0]        direction,
   output logic              hit_active
);

   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HC_W   = ($clog2(HIT_TICKS + 1) < 2) ? 2 : $clog2(HIT_TICKS + 1);
   localparam int PH_MAX = 2 * (N_FRAMES - 1);
   localparam int PX_HI  = X_MAX - SPR_W + 1;
   localparam int PY_HI  = Y_MAX - SPR_H + 1;
   localparam int RST_X  = START_X - SPR_W / 2;
   localparam int RST_Y  = START_Y - SPR_H / 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_HIT  = 2'd2
   } state_t;

   function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                            input logic signed [10:0] lo,
                                            input logic signed [10:0] hi);
      logic [9:0] r;
      if (v < lo) begin
         r = lo[9:0];
      end else if (v > hi) begin
         r = hi[9:0];
      end else begin
         r = v[9:0];
      end
      return r;
   endfunction

   state_t            state_r, state_s;
   logic [9:0]        pos_x_r, pos_x_s, pos_y_r, pos_y_s;
   logic [1:0]        dir_r, dir_s;
   logic [3:0]        phase_r, phase_s, phase_inc_s, frame_s;
   logic              hit_active_r, hit_active_s;
   logic [HC_W-1:0]   hit_cnt_r, hit_cnt_s;
   logic [DIV_W-1:0]  div_cnt_r, div_cnt_s;
   logic              fclk_r, edge_s, tick_s;
   logic              key_valid_s;
   logic [1:0]        key_dir_s;
   logic signed [10:0] key_dx_s, key_dy_s, knock_dx_s, knock_dy_s;
   logic [9:0]        walk_x_s, walk_y_s, knock_x_s, knock_y_s;
   logic signed [11:0] dx_pix_s, dy_pix_s;
   logic              inside_s;

   // Frame-clock edge detect and movement-tick divider
   always_comb begin
      edge_s    = frame_clk & ~fclk_r;
      tick_s    = 1'b0;
      div_cnt_s = div_cnt_r;
      if (edge_s) begin
         if (div_cnt_r == DIV_W'(DIV - 1)) begin
            div_cnt_s = {DIV_W{1'b0}};
            tick_s    = 1'b1;
         end else begin
            div_cnt_s = div_cnt_r + DIV_W'(1);
         end
      end else begin
         div_cnt_s = div_cnt_r;
      end
   end

   // Key decode, knockback vector (opposite of facing) and clamped candidate positions
   always_comb begin
      key_valid_s = 1'b0;
      key_dir_s   = dir_r;
      key_dx_s    = 11'sd0;
      key_dy_s    = 11'sd0;
      knock_dx_s  = 11'sd0;
      knock_dy_s  = 11'sd0;
      case (keycode)
         8'd26:   begin key_valid_s = 1'b1; key_dir_s = 2'd2; key_dy_s = -$signed(11'(STEP)); end
         8'd22:   begin key_valid_s = 1'b1; key_dir_s = 2'd0; key_dy_s =  $signed(11'(STEP)); end
         8'd4:    begin key_valid_s = 1'b1; key_dir_s = 2'd1; key_dx_s = -$signed(11'(STEP)); end
         8'd7:    begin key_valid_s = 1'b1; key_dir_s = 2'd3; key_dx_s =  $signed(11'(STEP)); end
         default: begin key_valid_s = 1'b0; end
      endcase
      case (dir_r)
         2'd0:    knock_dy_s = -$signed(11'(KNOCK));
         2'd1:    knock_dx_s =  $signed(11'(KNOCK));
         2'd2:    knock_dy_s =  $signed(11'(KNOCK));
         2'd3:    knock_dx_s = -$signed(11'(KNOCK));
         default: knock_dx_s = 11'sd0;
      endcase
      walk_x_s  = clamp_pos($signed({1'b0, pos_x_r}) + key_dx_s, 11'(X_MIN), 11'(PX_HI));
      walk_y_s  = clamp_pos($signed({1'b0, pos_y_r}) + key_dy_s, 11'(Y_MIN), 11'(PY_HI));
      knock_x_s = clamp_pos($signed({1'b0, pos_x_r}) + knock_dx_s, 11'(X_MIN), 11'(PX_HI));
      knock_y_s = clamp_pos($signed({1'b0, pos_y_r}) + knock_dy_s, 11'(Y_MIN), 11'(PY_HI));
      phase_inc_s = (PH_MAX == 0) ? 4'd0 :
                    (phase_r == 4'(PH_MAX - 1)) ? 4'd0 : phase_r + 4'd1;
   end

   // Mode FSM: walking, hit/knockback, and return to idle
   always_comb begin
      state_s      = state_r;
      pos_x_s      = pos_x_r;
      pos_y_s      = pos_y_r;
      dir_s        = dir_r;
      phase_s      = phase_r;
      hit_active_s = hit_active_r;
      hit_cnt_s    = hit_cnt_r;
      case (state_r)
         ST_IDLE, ST_WALK: begin
            if (hit) begin
               state_s      = ST_HIT;
               pos_x_s      = knock_x_s;
               pos_y_s      = knock_y_s;
               hit_active_s = 1'b1;
               hit_cnt_s    = {HC_W{1'b0}};
               phase_s      = 4'd0;
            end else if (tick_s) begin
               if (key_valid_s) begin
                  state_s = ST_WALK;
                  dir_s   = key_dir_s;
                  pos_x_s = walk_x_s;
                  pos_y_s = walk_y_s;
                  phase_s = phase_inc_s;
               end else begin
                  state_s = ST_IDLE;
                  phase_s = 4'd0;
               end
            end else begin
               state_s = state_r;
            end
         end
         ST_HIT: begin
            if (tick_s) begin
               if (hit_cnt_r == HC_W'(HIT_TICKS - 1)) begin
                  state_s      = ST_IDLE;
                  hit_active_s = 1'b0;
                  hit_cnt_s    = {HC_W{1'b0}};
               end else begin
                  hit_cnt_s = hit_cnt_r + HC_W'(1);
               end
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s      = ST_IDLE;
            hit_active_s = 1'b0;
            phase_s      = 4'd0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r      <= ST_IDLE;
         pos_x_r      <= 10'(RST_X);
         pos_y_r      <= 10'(RST_Y);
         dir_r        <= 2'd0;
         phase_r      <= 4'd0;
         hit_active_r <= 1'b0;
         hit_cnt_r    <= {HC_W{1'b0}};
         div_cnt_r    <= {DIV_W{1'b0}};
         fclk_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         pos_x_r      <= pos_x_s;
         pos_y_r      <= pos_y_s;
         dir_r        <= dir_s;
         phase_r      <= phase_s;
         hit_active_r <= hit_active_s;
         hit_cnt_r    <= hit_cnt_s;
         div_cnt_r    <= div_cnt_s;
         fclk_r       <= frame_clk;
      end
   end

   // Per-pixel ownership and sheet address; blink hides the sprite when counter bit 1 is set
   always_comb begin
      frame_s  = phase_r[0] ? 4'(4'd1 + (phase_r >> 1)) : 4'd0;
      dx_pix_s = $signed({3'b000, PixelX}) - $signed({2'b00, pos_x_r});
      dy_pix_s = $signed({3'b000, PixelY}) - $signed({2'b00, pos_y_r});
      inside_s = (dx_pix_s >= 12'sd0) && (dx_pix_s < $signed(12'(SPR_W))) &&
                 (dy_pix_s >= 12'sd0) && (dy_pix_s < $signed(12'(SPR_H)));
      if (inside_s) begin
         obj_address = ADDR_W'(32'(dx_pix_s) + 32'(dy_pix_s) * 32'(SPR_W) +
                       32'(SPR_W * SPR_H) * (32'(dir_r) * 32'(N_FRAMES) + 32'(frame_s)));
      end else begin
         obj_address = {ADDR_W{1'b0}};
      end
      is_obj = inside_s & ~(hit_active_r & hit_cnt_r[1]);
   end

   assign pos_x      = pos_x_r;
   assign pos_y      = pos_y_r;
   assign direction  = dir_r;
   assign hit_active = hit_active_r;

endmodule

// File: tb/tb_sprite_walker.sv
// Directed bench for sprite_walker: default instance plus a STEP=3/DIV=1 instance
// used to reach odd positions and partial steps at the field bounds.
module tb_sprite_walker;

   logic        Clk = 1'b0;
   logic        Reset, frame_clk, hit, hit2;
   logic [7:0]  keycode, keycode2;
   logic [8:0]  PixelX, PixelY;
   logic        is_obj, hit_active, is_obj_b, hit_active_b;
   logic [15:0] obj_address, obj_address_b;
   logic [9:0]  pos_x, pos_y, pos_x_b, pos_y_b;
   logic [1:0]  direction, direction_b;
   int          total = 0;
   int          bad = 0;

   always #10 Clk = ~Clk;

   sprite_walker dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .hit(hit),
      .PixelX(PixelX), .PixelY(PixelY), .is_obj(is_obj), .obj_address(obj_address),
      .pos_x(pos_x), .pos_y(pos_y), .direction(direction), .hit_active(hit_active)
   );

   sprite_walker #(.DIV(1), .STEP(3)) dut_b (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode2), .hit(hit2),
      .PixelX(PixelX), .PixelY(PixelY), .is_obj(is_obj_b), .obj_address(obj_address_b),
      .pos_x(pos_x_b), .pos_y(pos_y_b), .direction(direction_b), .hit_active(hit_active_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fedge();
      @(negedge Clk); frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic ticks(input int n);
      repeat (n * 4) fedge();
   endtask

   task automatic probe(input int x, input int y);
      PixelX = 9'(x);
      PixelY = 9'(y);
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clk); Reset = 1'b1; frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic pulse_hit();
      @(negedge Clk); hit = 1'b1;
      @(negedge Clk); hit = 1'b0;
      #1;
   endtask

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; hit = 1'b0; hit2 = 1'b0;
      keycode = 8'd0; keycode2 = 8'd0; PixelX = 9'd0; PixelY = 9'd0;
      do_reset();

      // reset state and sprite window
      probe(140, 88);
      check("rst_pos_x", 32'(pos_x), 32'd140);
      check("rst_pos_y", 32'(pos_y), 32'd88);
      check("rst_dir", 32'(direction), 32'd0);
      check("rst_hit", 32'(hit_active), 32'd0);
      check("rst_obj", 32'(is_obj), 32'd1);
      check("rst_addr", 32'(obj_address), 32'd0);
      probe(139, 88);
      check("left_out_obj", 32'(is_obj), 32'd0);
      check("left_out_addr", 32'(obj_address), 32'd0);
      probe(179, 151);
      check("last_pix_addr", 32'(obj_address), 32'd2559);
      probe(180, 88);
      check("right_out_obj", 32'(is_obj), 32'd0);

      // walk right: phase 1,2,3,0 -> frames 1,0,2,0
      keycode = 8'd7;
      ticks(1); probe(149, 89);
      check("walk1_x", 32'(pos_x), 32'd142);
      check("walk1_dir", 32'(direction), 32'd3);
      check("walk1_addr", 32'(obj_address), 32'd25647);
      ticks(1); probe(144, 88);
      check("walk2_addr", 32'(obj_address), 32'd23040);
      ticks(1); probe(146, 88);
      check("walk3_addr", 32'(obj_address), 32'd28160);
      ticks(1); probe(148, 88);
      check("walk4_x", 32'(pos_x), 32'd148);
      check("walk4_addr", 32'(obj_address), 32'd23040);
      ticks(1); probe(150, 88);
      check("walk5_addr", 32'(obj_address), 32'd25600);
      keycode = 8'd0;
      ticks(1); probe(150, 88);
      check("release_x", 32'(pos_x), 32'd150);
      check("release_addr", 32'(obj_address), 32'd23040);

      // direction changes keep the phase running
      keycode = 8'd4;
      ticks(1); probe(148, 88);
      check("left_addr", 32'(obj_address), 32'd10240);
      keycode = 8'd26;
      ticks(1); probe(148, 86);
      check("up_y", 32'(pos_y), 32'd86);
      check("up_addr", 32'(obj_address), 32'd15360);
      keycode = 8'd22;
      ticks(1); probe(148, 88);
      check("down_addr", 32'(obj_address), 32'd5120);
      keycode = 8'd0;
      ticks(1);

      // tick spacing: one tick per four frame_clk edges
      keycode = 8'd26;
      repeat (3) fedge();
      check("space3_y", 32'(pos_y), 32'd88);
      fedge();
      check("space4_y", 32'(pos_y), 32'd86);
      repeat (3) fedge();
      check("space7_y", 32'(pos_y), 32'd86);
      fedge();
      check("space8_y", 32'(pos_y), 32'd84);
      keycode = 8'd0;
      ticks(1);

      // right bound: position held, phase keeps advancing
      keycode = 8'd7;
      ticks(65);
      check("clamp65_x", 32'(pos_x), 32'd278);
      ticks(1);
      check("clamp66_x", 32'(pos_x), 32'd280);
      ticks(1); probe(280, 84);
      check("clamp67_x", 32'(pos_x), 32'd280);
      check("clamp67_addr", 32'(obj_address), 32'd28160);
      keycode = 8'd0;

      // STEP=3 instance: partial steps into the top and right bounds
      keycode2 = 8'd26;
      repeat (29) fedge();
      check("b_up29_y", 32'(pos_y_b), 32'd1);
      fedge();
      check("b_up30_y", 32'(pos_y_b), 32'd0);
      fedge();
      check("b_up31_y", 32'(pos_y_b), 32'd0);
      keycode2 = 8'd7;
      repeat (46) fedge();
      check("b_rt46_x", 32'(pos_x_b), 32'd278);
      fedge();
      check("b_rt47_x", 32'(pos_x_b), 32'd280);
      fedge();
      check("b_rt48_x", 32'(pos_x_b), 32'd280);
      check("b_rt_dir", 32'(direction_b), 32'd3);
      keycode2 = 8'd0;

      // hit while facing right at x=200
      do_reset();
      keycode = 8'd7;
      ticks(30);
      check("pre_hit_x", 32'(pos_x), 32'd200);
      keycode = 8'd0;
      ticks(1);
      pulse_hit();
      probe(192, 88);
      check("hit_x", 32'(pos_x), 32'd192);
      check("hit_act", 32'(hit_active), 32'd1);
      check("hit_obj0", 32'(is_obj), 32'd1);
      check("hit_addr0", 32'(obj_address), 32'd23040);
      keycode = 8'd4;
      for (int n = 1; n <= 16; n++) begin
         ticks(1); #1;
         check($sformatf("hitx_t%0d", n), 32'(pos_x), 32'd192);
         check($sformatf("hitdir_t%0d", n), 32'(direction), 32'd3);
         check($sformatf("hitact_t%0d", n), 32'(hit_active), (n < 16) ? 32'd1 : 32'd0);
         check($sformatf("blink_t%0d", n), 32'(is_obj),
               ((n < 16) && (((n >> 1) & 1) == 1)) ? 32'd0 : 32'd1);
         if (n == 5) begin
            pulse_hit();
            check("rehit_x", 32'(pos_x), 32'd192);
            check("rehit_act", 32'(hit_active), 32'd1);
         end
      end
      ticks(1);
      check("post_hit_x", 32'(pos_x), 32'd190);
      check("post_hit_dir", 32'(direction), 32'd1);

      // simultaneous hit and tick: knockback wins, no step
      keycode = 8'd7;
      ticks(5);
      check("sim_pre_x", 32'(pos_x), 32'd200);
      repeat (3) fedge();
      @(negedge Clk); frame_clk = 1'b1; hit = 1'b1;
      @(negedge Clk); hit = 1'b0;
      @(negedge Clk); frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
      check("sim_x", 32'(pos_x), 32'd192);
      check("sim_act", 32'(hit_active), 32'd1);
      ticks(7); probe(192, 88);
      check("sim_t7_act", 32'(hit_active), 32'd1);
      check("sim_t7_obj", 32'(is_obj), 32'd0);

      // reset overrides hit mode
      do_reset();
      probe(140, 88);
      check("rst2_act", 32'(hit_active), 32'd0);
      check("rst2_x", 32'(pos_x), 32'd140);
      check("rst2_y", 32'(pos_y), 32'd88);
      check("rst2_obj", 32'(is_obj), 32'd1);

      // knockback facing down pushes the sprite up
      keycode = 8'd0;
      pulse_hit();
      check("knock_up_y", 32'(pos_y), 32'd80);
      check("knock_up_x", 32'(pos_x), 32'd140);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
